// File: rtl/alu_cmd_if.sv
// Byte-stream, ALU and transmit signals of the ALU command controller.
// master = controller side, slave = environment (RX/TX links and ALU).
interface alu_cmd_if #(
    parameter int DATA_WIDTH = 8
);
    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic [DATA_WIDTH-1:0]   alu_a;
    logic [DATA_WIDTH-1:0]   alu_b;
    logic [3:0]              alu_function;
    logic                    alu_enable;
    logic [2*DATA_WIDTH-1:0] alu_result;
    logic                    alu_result_valid;
    logic [7:0]              tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic                    busy;
    logic                    rx_overrun;

    modport master (
        input  rx_data,
        input  rx_valid,
        input  alu_result,
        input  alu_result_valid,
        input  tx_ready,
        output alu_a,
        output alu_b,
        output alu_function,
        output alu_enable,
        output tx_data,
        output tx_valid,
        output busy,
        output rx_overrun
    );

    modport slave (
        output rx_data,
        output rx_valid,
        output alu_result,
        output alu_result_valid,
        output tx_ready,
        input  alu_a,
        input  alu_b,
        input  alu_function,
        input  alu_enable,
        input  tx_data,
        input  tx_valid,
        input  busy,
        input  rx_overrun
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// ALU command controller: parses CC/A/B/FUNC frames, runs one ALU
// request, returns the 16-bit result LSB first (or an error byte).
module alu_cmd_ctrl #(
    parameter int         DATA_WIDTH  = 8,
    parameter logic [7:0] CMD_HDR     = 8'hCC,
    parameter logic [7:0] ERR_CODE    = 8'hEE,
    parameter int         ALU_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       reset,
    alu_cmd_if.master  bus
);
    localparam int TW = $clog2(ALU_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_A,
        S_GET_B,
        S_GET_FUNC,
        S_ALU_REQ,
        S_ALU_WAIT,
        S_SEND_LO,
        S_SEND_HI,
        S_SEND_ERR
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [3:0]              r_fn;
    logic [2*DATA_WIDTH-1:0] r_result;
    logic [TW-1:0]           r_timer;
    logic                    r_overrun;

    logic       w_ld_a;
    logic       w_ld_b;
    logic       w_ld_fn;
    logic       w_cap;
    logic       w_tmr_clr;
    logic       w_tmr_inc;
    logic       w_drop;
    logic       w_tx_valid;
    logic [7:0] w_tx_data;
    logic       w_alu_en;

    always_comb begin
        w_next     = r_state;
        w_ld_a     = 1'b0;
        w_ld_b     = 1'b0;
        w_ld_fn    = 1'b0;
        w_cap      = 1'b0;
        w_tmr_clr  = 1'b0;
        w_tmr_inc  = 1'b0;
        w_drop     = 1'b0;
        w_tx_valid = 1'b0;
        w_tx_data  = 8'h00;
        w_alu_en   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.rx_valid && bus.rx_data == CMD_HDR)
                    w_next = S_GET_A;
            end
            S_GET_A: begin
                if (bus.rx_valid) begin
                    w_ld_a = 1'b1;
                    w_next = S_GET_B;
                end
            end
            S_GET_B: begin
                if (bus.rx_valid) begin
                    w_ld_b = 1'b1;
                    w_next = S_GET_FUNC;
                end
            end
            S_GET_FUNC: begin
                if (bus.rx_valid) begin
                    w_ld_fn = 1'b1;
                    w_next  = S_ALU_REQ;
                end
            end
            S_ALU_REQ: begin
                w_alu_en  = 1'b1;
                w_tmr_clr = 1'b1;
                w_drop    = bus.rx_valid;
                w_next    = S_ALU_WAIT;
            end
            S_ALU_WAIT: begin
                w_drop = bus.rx_valid;
                // ALU_WAIT lasts at most ALU_TIMEOUT cycles
                if (bus.alu_result_valid) begin
                    w_cap  = 1'b1;
                    w_next = S_SEND_LO;
                end else if (r_timer == TW'(ALU_TIMEOUT - 1)) begin
                    w_next = S_SEND_ERR;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            S_SEND_LO: begin
                w_drop     = bus.rx_valid;
                w_tx_valid = 1'b1;
                w_tx_data  = r_result[7:0];
                if (bus.tx_ready)
                    w_next = S_SEND_HI;
            end
            S_SEND_HI: begin
                w_drop     = bus.rx_valid;
                w_tx_valid = 1'b1;
                w_tx_data  = r_result[15:8];
                if (bus.tx_ready)
                    w_next = S_IDLE;
            end
            S_SEND_ERR: begin
                w_drop     = bus.rx_valid;
                w_tx_valid = 1'b1;
                w_tx_data  = ERR_CODE;
                if (bus.tx_ready)
                    w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a  <= '0;
            r_b  <= '0;
            r_fn <= '0;
        end else begin
            if (w_ld_a)
                r_a <= DATA_WIDTH'(bus.rx_data);
            if (w_ld_b)
                r_b <= DATA_WIDTH'(bus.rx_data);
            if (w_ld_fn)
                r_fn <= bus.rx_data[3:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result <= '0;
        end else if (w_cap) begin
            r_result <= bus.alu_result;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (w_tmr_clr) begin
            r_timer <= '0;
        end else if (w_tmr_inc) begin
            r_timer <= r_timer + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_drop;
        end
    end

    assign bus.alu_a        = r_a;
    assign bus.alu_b        = r_b;
    assign bus.alu_function = r_fn;
    assign bus.alu_enable   = w_alu_en;
    assign bus.tx_data      = w_tx_data;
    assign bus.tx_valid     = w_tx_valid;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.rx_overrun   = r_overrun;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed table-driven bench for alu_cmd_ctrl; the bench plays the
// RX link, the ALU and the TX link.
module tb_alu_cmd_ctrl;
    logic clk;
    logic reset;

    alu_cmd_if #(.DATA_WIDTH(8)) bus ();

    alu_cmd_ctrl #(
        .DATA_WIDTH (8),
        .CMD_HDR    (8'hCC),
        .ERR_CODE   (8'hEE),
        .ALU_TIMEOUT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  f;
        logic        resp;
        logic [15:0] res;
        logic [3:0]  exp_fn;
        logic [7:0]  exp_lo;
        logic [7:0]  exp_hi;
    } vec_t;

    vec_t vecs[4];
    int   n_chk;
    int   n_fail;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        bus.rx_data  = d;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int cnt;
        send(8'hCC);
        send(v.a);
        send(v.b);
        send(v.f);
        chk("alu_enable_req", 32'(bus.alu_enable), 32'd1);
        chk("alu_a", 32'(bus.alu_a), 32'(v.a));
        chk("alu_b", 32'(bus.alu_b), 32'(v.b));
        chk("alu_fn", 32'(bus.alu_function), 32'(v.exp_fn));
        chk("busy_req", 32'(bus.busy), 32'd1);
        tick();
        chk("alu_enable_drop", 32'(bus.alu_enable), 32'd0);
        if (v.resp) begin
            bus.alu_result       = v.res;
            bus.alu_result_valid = 1'b1;
            tick();
            bus.alu_result_valid = 1'b0;
            chk("tx_valid_lo", 32'(bus.tx_valid), 32'd1);
            chk("tx_data_lo", 32'(bus.tx_data), 32'(v.exp_lo));
            bus.tx_ready = 1'b1;
            tick();
            chk("tx_valid_hi", 32'(bus.tx_valid), 32'd1);
            chk("tx_data_hi", 32'(bus.tx_data), 32'(v.exp_hi));
            tick();
        end else begin
            cnt = 0;
            while (!bus.tx_valid && cnt < 12) begin
                tick();
                cnt++;
            end
            chk("err_latency_ok",
                32'((cnt >= 4) && (cnt <= 5)), 32'd1);
            chk("tx_data_err", 32'(bus.tx_data), 32'(v.exp_lo));
            bus.tx_ready = 1'b1;
            tick();
        end
        bus.tx_ready = 1'b0;
        chk("tx_valid_end", 32'(bus.tx_valid), 32'd0);
        chk("busy_end", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        vecs[0] = '{8'h05, 8'h03, 8'h00, 1'b1, 16'h0008, 4'h0, 8'h08, 8'h00};
        vecs[1] = '{8'hFF, 8'hFF, 8'h02, 1'b1, 16'hFE01, 4'h2, 8'h01, 8'hFE};
        vecs[2] = '{8'h01, 8'h02, 8'h0F, 1'b0, 16'h0000, 4'hF, 8'hEE, 8'h00};
        vecs[3] = '{8'h10, 8'h20, 8'hA5, 1'b1, 16'h1234, 4'h5, 8'h34, 8'h12};

        reset                = 1'b0;
        bus.rx_data          = 8'h00;
        bus.rx_valid         = 1'b0;
        bus.alu_result       = 16'h0000;
        bus.alu_result_valid = 1'b0;
        bus.tx_ready         = 1'b0;
        tick();
        tick();
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
        chk("rst_alu_en", 32'(bus.alu_enable), 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 4; i++)
            run_vec(vecs[i]);

        // tx_ready held low for 10 cycles in SEND_LO
        send(8'hCC);
        send(8'h05);
        send(8'h03);
        send(8'h00);
        tick();
        bus.alu_result       = 16'hBEEF;
        bus.alu_result_valid = 1'b1;
        tick();
        bus.alu_result_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(bus.tx_valid), 32'd1);
            chk("stall_data", 32'(bus.tx_data), 32'hEF);
            tick();
        end
        bus.tx_ready = 1'b1;
        tick();
        chk("stall_hi", 32'(bus.tx_data), 32'hBE);
        tick();
        bus.tx_ready = 1'b0;
        chk("stall_done", 32'(bus.busy), 32'd0);

        // junk before header, CC as data, overrun in ALU_WAIT
        send(8'h12);
        send(8'h34);
        chk("junk_busy", 32'(bus.busy), 32'd0);
        send(8'hCC);
        send(8'hCC);
        send(8'h07);
        send(8'hF9);
        chk("t5_alu_a", 32'(bus.alu_a), 32'hCC);
        chk("t5_alu_b", 32'(bus.alu_b), 32'h07);
        chk("t5_alu_fn", 32'(bus.alu_function), 32'h9);
        chk("t5_no_ovr", 32'(bus.rx_overrun), 32'd0);
        tick();
        send(8'h55);
        chk("t5_overrun", 32'(bus.rx_overrun), 32'd1);
        bus.alu_result       = 16'h0C5A;
        bus.alu_result_valid = 1'b1;
        tick();
        bus.alu_result_valid = 1'b0;
        chk("t5_ovr_clear", 32'(bus.rx_overrun), 32'd0);
        chk("t5_tx_lo", 32'(bus.tx_data), 32'h5A);
        bus.tx_ready = 1'b1;
        tick();
        chk("t5_tx_hi", 32'(bus.tx_data), 32'h0C);
        tick();
        bus.tx_ready = 1'b0;

        // asynchronous reset during SEND_HI
        send(8'hCC);
        send(8'h22);
        send(8'h33);
        send(8'h01);
        tick();
        bus.alu_result       = 16'hAB12;
        bus.alu_result_valid = 1'b1;
        tick();
        bus.alu_result_valid = 1'b0;
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        chk("t6_in_hi", 32'(bus.tx_data), 32'hAB);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("t6_tx_data", 32'(bus.tx_data), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_alu_a", 32'(bus.alu_a), 32'd0);
        chk("t6_alu_b", 32'(bus.alu_b), 32'd0);
        chk("t6_alu_fn", 32'(bus.alu_function), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        run_vec(vecs[3]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
